// File: rtl/outer_product_accumulator.sv
// ---------------------------------------------------------------------------
// outer_product_accumulator
//
// Consumes the 3x3 operand memory bank and computes C = W*X as a sum of three
// outer products. On a rising edge of the bank's start flag it steps through
// unload1/unload2/unload3, one cycle each. In step k the bank presents column
// k of W (w1..w3) and row k of X (x1..x3), and every C[i][j] accumulates
// w(i+1)*x(j+1). The finished result is held on c_out with valid high until
// the next run or reset.
//
// Ports
//   clk            system clock, rising edge
//   clear          asynchronous active-high reset
//   start          bank operands-loaded flag (level; only its rising edge counts)
//   w1..w3         W[0][k], W[1][k], W[2][k] for the current step k
//   x1..x3         X[k][0], X[k][1], X[k][2] for the current step k
//   unload1..3     one-hot step select back to the bank
//   busy           high while stepping
//   done           one-cycle pulse when the result completes
//   valid          c_out holds a complete, stable result
//   c_out          C[i][j] at c_out[(3*i+j)*ACC_W +: ACC_W]
//
// State | meaning
//   IDLE | waiting for a start edge
//   U1   | step 0 operands selected, accumulate on exit
//   U2   | step 1 operands selected, accumulate on exit
//   U3   | step 2 operands selected, accumulate on exit
//   DONE | result complete (one cycle), may relaunch directly
// ---------------------------------------------------------------------------
module outer_product_accumulator #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 10
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic [DATA_W-1:0]    w1,
  input  logic [DATA_W-1:0]    w2,
  input  logic [DATA_W-1:0]    w3,
  input  logic [DATA_W-1:0]    x1,
  input  logic [DATA_W-1:0]    x2,
  input  logic [DATA_W-1:0]    x3,
  output logic                 unload1,
  output logic                 unload2,
  output logic                 unload3,
  output logic                 busy,
  output logic                 done,
  output logic                 valid,
  output logic [9*ACC_W-1:0]   c_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_U1,
    S_U2,
    S_U3,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              start_prev_q;
  logic              unload1_q, unload2_q, unload3_q;
  logic              busy_q, done_q;
  logic              valid_q, valid_d;
  logic [ACC_W-1:0]  acc_q [9];
  logic [ACC_W-1:0]  acc_d [9];
  logic [DATA_W-1:0] w_vec [3];
  logic [DATA_W-1:0] x_vec [3];
  logic              trig;
  logic              launch;
  logic              step_en;

  assign w_vec[0] = w1;
  assign w_vec[1] = w2;
  assign w_vec[2] = w3;
  assign x_vec[0] = x1;
  assign x_vec[1] = x2;
  assign x_vec[2] = x3;

  always_comb begin
    trig    = start & ~start_prev_q;
    // Edges arriving mid-run are dropped, not queued.
    launch  = trig & ((state_q == S_IDLE) || (state_q == S_DONE));
    step_en = (state_q == S_U1) || (state_q == S_U2) || (state_q == S_U3);

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch) state_d = S_U1;
      S_U1:    state_d = S_U2;
      S_U2:    state_d = S_U3;
      S_U3:    state_d = S_DONE;
      S_DONE:  state_d = launch ? S_U1 : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    for (int k = 0; k < 9; k++) acc_d[k] = acc_q[k];
    if (launch) begin
      for (int k = 0; k < 9; k++) acc_d[k] = '0;
    end else if (step_en) begin
      // Operands are widened before the multiply so the product keeps all bits.
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          acc_d[3*i+j] = acc_q[3*i+j] + (ACC_W'(w_vec[i]) * ACC_W'(x_vec[j]));
        end
      end
    end

    valid_d = valid_q;
    if (launch)                  valid_d = 1'b0;
    else if (state_d == S_DONE)  valid_d = 1'b1;
  end

  // Outputs are decoded from the next state so they line up with the state
  // they describe rather than lagging it by a cycle.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      unload1_q    <= 1'b0;
      unload2_q    <= 1'b0;
      unload3_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      for (int k = 0; k < 9; k++) acc_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start;
      unload1_q    <= (state_d == S_U1);
      unload2_q    <= (state_d == S_U2);
      unload3_q    <= (state_d == S_U3);
      busy_q       <= (state_d == S_U1) || (state_d == S_U2) || (state_d == S_U3);
      done_q       <= (state_d == S_DONE);
      valid_q      <= valid_d;
      for (int k = 0; k < 9; k++) acc_q[k] <= acc_d[k];
    end
  end

  assign unload1 = unload1_q;
  assign unload2 = unload2_q;
  assign unload3 = unload3_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign valid   = valid_q;

  for (genvar k = 0; k < 9; k++) begin : g_cout
    assign c_out[k*ACC_W +: ACC_W] = acc_q[k];
  end

endmodule

// File: tb/tb_outer_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_outer_product_accumulator
//
// Directed bench for outer_product_accumulator. A small behavioural model of
// the operand bank drives w*/x* from the unload lines; expected results are
// hand-computed matrices.
// ---------------------------------------------------------------------------
module tb_outer_product_accumulator;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [3:0]  w1, w2, w3, x1, x2, x3;
  logic        unload1, unload2, unload3;
  logic        busy, done, valid;
  logic [89:0] c_out;

  logic [3:0]  wm [3][3];
  logic [3:0]  xm [3][3];
  logic [2:0]  ul;

  int errors = 0;
  int checks = 0;

  int cyc = 0, u1_cnt = 0, u2_cnt = 0, u3_cnt = 0, done_cnt = 0, ovl_cnt = 0;
  int u1_at = 0, u2_at = 0, u3_at = 0, done_at = 0;

  int exp_id [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int exp_m6 [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

  outer_product_accumulator #(.DATA_W(4), .ACC_W(10)) dut (
    .clk     (clk),
    .clear   (clear),
    .start   (start),
    .w1      (w1),
    .w2      (w2),
    .w3      (w3),
    .x1      (x1),
    .x2      (x2),
    .x3      (x3),
    .unload1 (unload1),
    .unload2 (unload2),
    .unload3 (unload3),
    .busy    (busy),
    .done    (done),
    .valid   (valid),
    .c_out   (c_out)
  );

  always #5 clk = ~clk;

  assign ul = {unload3, unload2, unload1};

  // Bank model: combinational from unload, zero when nothing is selected.
  always_comb begin
    w1 = '0; w2 = '0; w3 = '0;
    x1 = '0; x2 = '0; x3 = '0;
    for (int k = 0; k < 3; k++) begin
      if (ul[k]) begin
        w1 = wm[0][k]; w2 = wm[1][k]; w3 = wm[2][k];
        x1 = xm[k][0]; x2 = xm[k][1]; x3 = xm[k][2];
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (unload1) begin u1_cnt++; u1_at = cyc; end
    if (unload2) begin u2_cnt++; u2_at = cyc; end
    if (unload3) begin u3_cnt++; u3_at = cyc; end
    if (done)    begin done_cnt++; done_at = cyc; end
    if ((32'(unload1) + 32'(unload2) + 32'(unload3)) > 1) ovl_cnt++;
  end

  function automatic logic [9:0] c_at(int i, int j);
    return c_out[(3*i+j)*10 +: 10];
  endfunction

  task automatic load_identity();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        wm[i][j] = (i == j) ? 4'd1 : 4'd0;
        xm[i][j] = 4'(3*i + j + 1);
      end
  endtask

  task automatic load_m6();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        wm[i][j] = 4'(3*i + j + 1);
        xm[i][j] = 4'(9 - (3*i + j));
      end
  endtask

  // Waits negedge by negedge until done is seen, bounded to 20 cycles.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 20);
  endtask

  task automatic test_reset();
    clear = 1'b1;
    start = 1'b0;
    load_identity();
    repeat (2) @(negedge clk);
    checks++; if (ul !== 3'b000) begin errors++; $display("FAIL reset_unload got=%b exp=000", ul); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (c_out !== 90'd0) begin errors++; $display("FAIL reset_cout got=%h exp=0", c_out); end
    clear = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy got=%b exp=0", busy); end
  endtask

  task automatic test_identity();
    load_identity();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (ul !== 3'b001 || busy !== 1'b1) begin errors++; $display("FAIL id_step1 unload=%b busy=%b exp=001/1", ul, busy); end
    @(negedge clk);
    checks++; if (ul !== 3'b010) begin errors++; $display("FAIL id_step2 unload=%b exp=010", ul); end
    @(negedge clk);
    checks++; if (ul !== 3'b100) begin errors++; $display("FAIL id_step3 unload=%b exp=100", ul); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || valid !== 1'b1 || busy !== 1'b0 || ul !== 3'b000) begin
      errors++; $display("FAIL id_done done=%b valid=%b busy=%b unload=%b exp=1/1/0/000", done, valid, busy, ul);
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (c_at(k/3, k%3) !== 10'(exp_id[k])) begin
        errors++; $display("FAIL id_c[%0d] got=%0d exp=%0d", k, c_at(k/3, k%3), exp_id[k]);
      end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL id_after done=%b valid=%b exp=0/1", done, valid); end
    repeat (3) @(negedge clk);
    checks++; if (valid !== 1'b1 || c_at(2, 2) !== 10'd9) begin errors++; $display("FAIL id_hold valid=%b c22=%0d exp=1/9", valid, c_at(2, 2)); end
  endtask

  task automatic test_max();
    int n;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        wm[i][j] = 4'd15;
        xm[i][j] = 4'd15;
      end
    start = 1'b1;
    wait_done(n);
    start = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL max_latency got=%0d exp=4", n); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (c_at(k/3, k%3) !== 10'h2A3) begin
        errors++; $display("FAIL max_c[%0d] got=%0d exp=675", k, c_at(k/3, k%3));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_hold_start();
    int d0, a0, b0, e0, o0;
    load_identity();
    d0 = done_cnt; a0 = u1_cnt; b0 = u2_cnt; e0 = u3_cnt; o0 = ovl_cnt;
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL hold_done_count got=%0d exp=1", done_cnt - d0); end
    checks++; if (u1_cnt - a0 !== 1 || u2_cnt - b0 !== 1 || u3_cnt - e0 !== 1) begin
      errors++; $display("FAIL hold_unload_counts got=%0d/%0d/%0d exp=1/1/1", u1_cnt - a0, u2_cnt - b0, u3_cnt - e0);
    end
    checks++; if (u2_at !== u1_at + 1 || u3_at !== u2_at + 1 || done_at !== u3_at + 1) begin
      errors++; $display("FAIL hold_order u1=%0d u2=%0d u3=%0d done=%0d exp consecutive", u1_at, u2_at, u3_at, done_at);
    end
    checks++; if (ovl_cnt !== o0) begin errors++; $display("FAIL hold_overlap got=%0d exp=%0d", ovl_cnt, o0); end
  endtask

  task automatic test_repulse_u2();
    int d0;
    load_identity();
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (ul !== 3'b010) begin errors++; $display("FAIL rep_u2_state unload=%b exp=010", ul); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rep_u2_done_count got=%0d exp=1", done_cnt - d0); end
    checks++; if (valid !== 1'b1 || c_at(1, 1) !== 10'd5) begin errors++; $display("FAIL rep_u2_result valid=%b c11=%0d exp=1/5", valid, c_at(1, 1)); end
  endtask

  task automatic test_back_to_back();
    int n;
    load_identity();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b1 || c_at(0, 2) !== 10'd3) begin errors++; $display("FAIL b2b_first done=%b c02=%0d exp=1/3", done, c_at(0, 2)); end
    load_m6();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (ul !== 3'b001 || done !== 1'b0) begin errors++; $display("FAIL b2b_relaunch unload=%b done=%b exp=001/0", ul, done); end
    checks++; if (valid !== 1'b0 || c_out !== 90'd0) begin errors++; $display("FAIL b2b_cleared valid=%b c_out=%h exp=0/0", valid, c_out); end
    wait_done(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=3", n); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (c_at(k/3, k%3) !== 10'(exp_m6[k])) begin
        errors++; $display("FAIL b2b_c[%0d] got=%0d exp=%0d", k, c_at(k/3, k%3), exp_m6[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_clear_mid();
    int n, d0;
    load_identity();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (ul !== 3'b010 || c_at(0, 1) !== 10'd2) begin errors++; $display("FAIL clr_pre unload=%b c01=%0d exp=010/2", ul, c_at(0, 1)); end
    clear = 1'b1;
    #1;
    checks++; if (unload2 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clr_async unload2=%b busy=%b exp=0/0", unload2, busy); end
    checks++; if (c_out !== 90'd0 || valid !== 1'b0) begin errors++; $display("FAIL clr_cout c_out=%h valid=%b exp=0/0", c_out, valid); end
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_done(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL clr_restart_latency got=%0d exp=4", n); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (c_at(k/3, k%3) !== 10'(exp_id[k])) begin
        errors++; $display("FAIL clr_c[%0d] got=%0d exp=%0d", k, c_at(k/3, k%3), exp_id[k]);
      end
    end
    start = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL clr_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_matrix6();
    int n;
    load_m6();
    start = 1'b1;
    wait_done(n);
    start = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL m6_latency got=%0d exp=4", n); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (c_at(k/3, k%3) !== 10'(exp_m6[k])) begin
        errors++; $display("FAIL m6_c[%0d] got=%0d exp=%0d", k, c_at(k/3, k%3), exp_m6[k]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_max();
    test_hold_start();
    test_repulse_u2();
    test_back_to_back();
    test_clear_mid();
    test_matrix6();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
